// File: rtl/mc_ctrl_fsm_pkg.sv
// Multicycle controller package: state encodings, opcode/funct
// constants, datapath control codes and the decoded-instruction bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MEMWB = 4'd4,
        S_MW    = 4'd5,
        S_EXE   = 4'd6,
        S_WB    = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_TRAP  = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        C_ILL,
        C_LOAD,
        C_STORE,
        C_RALU,
        C_IALU,
        C_BRANCH,
        C_JUMP
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JMP  = 3'b010;
    localparam logic [2:0] NPC_REG  = 3'b011;
    localparam logic [2:0] NPC_EXC  = 3'b100;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;

    localparam logic [1:0] LS_BYTE  = 2'b00;
    localparam logic [1:0] LS_HALF  = 2'b01;
    localparam logic [1:0] LS_WORD  = 2'b10;

    typedef struct packed {
        iclass_t    cls;
        logic [2:0] alu_ctr;
        logic       alu_src;
        logic       ext_op;
        logic [1:0] ls_size;
        logic       is_bne;
        logic       link;
        logic       jreg;
        logic       rtype;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> IR/datapath bundle: instruction fields and flags in,
// every datapath control, debug state and status counters out.
interface mc_ctrl_fsm_if #(
    parameter int ALUCTR_W = 3,
    parameter int NPC_W    = 3,
    parameter int CNT_W    = 32
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_rdy;
    logic [3:0]          state;
    logic                PCWr;
    logic                IRWr;
    logic                MemRd;
    logic                MemWr;
    logic                RegWr;
    logic                ALUsrc;
    logic                Extop;
    logic [1:0]          RegDst;
    logic [1:0]          MemtoReg;
    logic [1:0]          ls_size;
    logic [NPC_W-1:0]    npc_sel;
    logic [ALUCTR_W-1:0] ALUctr;
    logic                illegal;
    logic [CNT_W-1:0]    retired_cnt;

    modport master (
        input  opcode, funct, zero, mem_rdy,
        output state, PCWr, IRWr, MemRd, MemWr, RegWr,
        output ALUsrc, Extop, RegDst, MemtoReg, ls_size,
        output npc_sel, ALUctr, illegal, retired_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_rdy,
        input  state, PCWr, IRWr, MemRd, MemWr, RegWr,
        input  ALUsrc, Extop, RegDst, MemtoReg, ls_size,
        input  npc_sel, ALUctr, illegal, retired_cnt
    );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Static instruction decode: opcode/funct -> instruction class plus the
// controls that depend only on the instruction, not on the state.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Classify the instruction and pick its ALU/extend/size controls.
    always_comb begin
        dec     = '0;
        dec.cls = C_ILL;
        unique case (opcode)
            OP_RTYPE: begin
                dec.rtype = 1'b1;
                unique case (funct)
                    FN_ADDU: begin dec.cls = C_RALU; dec.alu_ctr = ALU_ADD; end
                    FN_SUBU: begin dec.cls = C_RALU; dec.alu_ctr = ALU_SUB; end
                    FN_SLT:  begin dec.cls = C_RALU; dec.alu_ctr = ALU_SLT; end
                    FN_AND:  begin dec.cls = C_RALU; dec.alu_ctr = ALU_AND; end
                    FN_OR:   begin dec.cls = C_RALU; dec.alu_ctr = ALU_OR;  end
                    FN_JR:   begin dec.cls = C_JUMP; dec.jreg = 1'b1; end
                    FN_JALR: begin
                        dec.cls  = C_JUMP;
                        dec.jreg = 1'b1;
                        dec.link = 1'b1;
                    end
                    default: dec.cls = C_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.cls     = C_IALU;
                dec.alu_ctr = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.ext_op  = 1'b1;
            end
            OP_ORI: begin
                dec.cls     = C_IALU;
                dec.alu_ctr = ALU_OR;
                dec.alu_src = 1'b1;
            end
            OP_LUI: begin
                dec.cls     = C_IALU;
                dec.alu_ctr = ALU_LUI;
                dec.alu_src = 1'b1;
            end
            OP_LB: begin dec.cls = C_LOAD;  dec.ls_size = LS_BYTE; end
            OP_LH: begin dec.cls = C_LOAD;  dec.ls_size = LS_HALF; end
            OP_LW: begin dec.cls = C_LOAD;  dec.ls_size = LS_WORD; end
            OP_SB: begin dec.cls = C_STORE; dec.ls_size = LS_BYTE; end
            OP_SH: begin dec.cls = C_STORE; dec.ls_size = LS_HALF; end
            OP_SW: begin dec.cls = C_STORE; dec.ls_size = LS_WORD; end
            OP_BEQ: dec.cls = C_BRANCH;
            OP_BNE: begin dec.cls = C_BRANCH; dec.is_bne = 1'b1; end
            OP_J:   dec.cls = C_JUMP;
            OP_JAL: begin dec.cls = C_JUMP; dec.link = 1'b1; end
            default: dec.cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset controller: state register, sequencing,
// state-qualified datapath strobes, retired counter and sticky trap flag.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W    = 3,
    parameter int NPC_W       = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_WAIT    = 1,
    parameter int TRAP_VEC_EN = 1
) (
    input logic           clk,
    input logic           rst_n,
    mc_ctrl_fsm_if.master bus
);

    dec_t             dec;
    state_t           state;
    state_t           nxt;
    logic             rdy;
    logic             pc_wr;
    logic             ir_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
    logic             alu_src;
    logic             ext_op;
    logic             retire;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       ls_size;
    logic [2:0]       alu_ctr;
    logic [2:0]       npc_sel;
    logic             illegal;
    logic [CNT_W-1:0] cnt;

    mc_ctrl_decode u_dec (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .dec    (dec)
    );

    // Without wait support the memory is assumed to answer every cycle.
    assign rdy = (MEM_WAIT != 0) ? bus.mem_rdy : 1'b1;

    // Next-state selection; unused encodings fall back to IF.
    always_comb begin
        nxt = state;
        case (state)
            S_IF:    if (rdy) nxt = S_ID;
            S_ID: begin
                case (dec.cls)
                    C_LOAD, C_STORE: nxt = S_MA;
                    C_RALU, C_IALU:  nxt = S_EXE;
                    C_BRANCH:        nxt = S_BR;
                    C_JUMP:          nxt = S_JMP;
                    default:         nxt = S_TRAP;
                endcase
            end
            S_MA:    nxt = (dec.cls == C_STORE) ? S_MW : S_MR;
            S_MR:    if (rdy) nxt = S_MEMWB;
            S_MEMWB: nxt = S_IF;
            S_MW:    if (rdy) nxt = S_IF;
            S_EXE:   nxt = S_WB;
            S_WB:    nxt = S_IF;
            S_BR:    nxt = S_IF;
            S_JMP:   nxt = S_IF;
            S_TRAP:  nxt = (TRAP_VEC_EN != 0) ? S_IF : S_TRAP;
            default: nxt = S_IF;
        endcase
    end

    // Datapath controls from current state and decoded instruction.
    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        retire     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        ls_size    = LS_BYTE;
        alu_ctr    = ALU_ADD;
        npc_sel    = NPC_PC4;
        case (state)
            S_IF: begin
                mem_rd = 1'b1;
                if (rdy) begin
                    pc_wr   = 1'b1;
                    ir_wr   = 1'b1;
                    npc_sel = NPC_PC4;
                end
            end
            S_MA: begin
                alu_src = 1'b1;
                ext_op  = 1'b1;
                alu_ctr = ALU_ADD;
            end
            S_MR: begin
                mem_rd  = 1'b1;
                ls_size = dec.ls_size;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = M2R_MEM;
                reg_dst    = DST_RT;
                ls_size    = dec.ls_size;
                retire     = 1'b1;
            end
            S_MW: begin
                mem_wr  = 1'b1;
                ls_size = dec.ls_size;
                retire  = rdy;
            end
            S_EXE: begin
                alu_ctr = dec.alu_ctr;
                alu_src = dec.alu_src;
                ext_op  = dec.ext_op;
            end
            S_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = M2R_ALU;
                reg_dst    = dec.rtype ? DST_RD : DST_RT;
                retire     = 1'b1;
            end
            S_BR: begin
                alu_ctr = ALU_SUB;
                pc_wr   = dec.is_bne ? ~bus.zero : bus.zero;
                npc_sel = NPC_BR;
                retire  = 1'b1;
            end
            S_JMP: begin
                pc_wr   = 1'b1;
                npc_sel = dec.jreg ? NPC_REG : NPC_JMP;
                if (dec.link) begin
                    reg_wr     = 1'b1;
                    mem_to_reg = M2R_PC4;
                    reg_dst    = dec.jreg ? DST_RD : DST_RA;
                end
                retire  = 1'b1;
            end
            S_TRAP: begin
                if (TRAP_VEC_EN != 0) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_EXC;
                end
            end
            default: ;
        endcase
    end

    // State register, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IF;
            illegal <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= nxt;
            if (state == S_TRAP) illegal <= 1'b1;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    // Write strobes are killed immediately while reset is held.
    assign bus.PCWr        = pc_wr  & rst_n;
    assign bus.IRWr        = ir_wr  & rst_n;
    assign bus.MemRd       = mem_rd & rst_n;
    assign bus.MemWr       = mem_wr & rst_n;
    assign bus.RegWr       = reg_wr & rst_n;
    assign bus.ALUsrc      = alu_src;
    assign bus.Extop       = ext_op;
    assign bus.RegDst      = reg_dst;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.ls_size     = ls_size;
    assign bus.ALUctr      = ALUCTR_W'(alu_ctr);
    assign bus.npc_sel     = NPC_W'(npc_sel);
    assign bus.state       = state;
    assign bus.illegal     = illegal;
    assign bus.retired_cnt = cnt;

endmodule
